// File: rtl/donut.sv
// Shaded-torus pixel generator: 2-stage pipeline from raster position to luma/visibility.
// Optional DONUT_SPIN_EN advances the shading angle once per frame at vblank start.
module donut (
    input  logic        clk50,
    input  logic        rst_n,
    input  logic [10:0] h_count,
    input  logic [9:0]  v_count,
    input  logic        frame,
    output logic [5:0]  donut_luma,
    output logic        donut_visible
);

    function automatic logic signed [7:0] sine_rom(input logic [5:0] idx);
        case (idx)
            6'd0:  sine_rom = 8'sd0;
            6'd1:  sine_rom = 8'sd12;
            6'd2:  sine_rom = 8'sd25;
            6'd3:  sine_rom = 8'sd37;
            6'd4:  sine_rom = 8'sd49;
            6'd5:  sine_rom = 8'sd60;
            6'd6:  sine_rom = 8'sd71;
            6'd7:  sine_rom = 8'sd81;
            6'd8:  sine_rom = 8'sd90;
            6'd9:  sine_rom = 8'sd98;
            6'd10: sine_rom = 8'sd106;
            6'd11: sine_rom = 8'sd112;
            6'd12: sine_rom = 8'sd117;
            6'd13: sine_rom = 8'sd122;
            6'd14: sine_rom = 8'sd125;
            6'd15: sine_rom = 8'sd126;
            6'd16: sine_rom = 8'sd127;
            6'd17: sine_rom = 8'sd126;
            6'd18: sine_rom = 8'sd125;
            6'd19: sine_rom = 8'sd122;
            6'd20: sine_rom = 8'sd117;
            6'd21: sine_rom = 8'sd112;
            6'd22: sine_rom = 8'sd106;
            6'd23: sine_rom = 8'sd98;
            6'd24: sine_rom = 8'sd90;
            6'd25: sine_rom = 8'sd81;
            6'd26: sine_rom = 8'sd71;
            6'd27: sine_rom = 8'sd60;
            6'd28: sine_rom = 8'sd49;
            6'd29: sine_rom = 8'sd37;
            6'd30: sine_rom = 8'sd25;
            6'd31: sine_rom = 8'sd12;
            6'd32: sine_rom = 8'sd0;
            6'd33: sine_rom = -8'sd12;
            6'd34: sine_rom = -8'sd25;
            6'd35: sine_rom = -8'sd37;
            6'd36: sine_rom = -8'sd49;
            6'd37: sine_rom = -8'sd60;
            6'd38: sine_rom = -8'sd71;
            6'd39: sine_rom = -8'sd81;
            6'd40: sine_rom = -8'sd90;
            6'd41: sine_rom = -8'sd98;
            6'd42: sine_rom = -8'sd106;
            6'd43: sine_rom = -8'sd112;
            6'd44: sine_rom = -8'sd117;
            6'd45: sine_rom = -8'sd122;
            6'd46: sine_rom = -8'sd125;
            6'd47: sine_rom = -8'sd126;
            6'd48: sine_rom = -8'sd127;
            6'd49: sine_rom = -8'sd126;
            6'd50: sine_rom = -8'sd125;
            6'd51: sine_rom = -8'sd122;
            6'd52: sine_rom = -8'sd117;
            6'd53: sine_rom = -8'sd112;
            6'd54: sine_rom = -8'sd106;
            6'd55: sine_rom = -8'sd98;
            6'd56: sine_rom = -8'sd90;
            6'd57: sine_rom = -8'sd81;
            6'd58: sine_rom = -8'sd71;
            6'd59: sine_rom = -8'sd60;
            6'd60: sine_rom = -8'sd49;
            6'd61: sine_rom = -8'sd37;
            6'd62: sine_rom = -8'sd25;
            6'd63: sine_rom = -8'sd12;
        endcase
    endfunction

    logic [7:0]         angle;
    logic [5:0]         rom_idx;
    logic signed [7:0]  sin_val;
    logic signed [7:0]  cos_val;

    logic signed [10:0] dx;
    logic signed [10:0] dy;
    logic signed [19:0] dx_ext;
    logic signed [19:0] dy_ext;
    logic signed [19:0] dx_sq;
    logic signed [19:0] dy_sq;
    logic signed [19:0] dot_sum;
    logic signed [19:0] dot_shift;
    logic [19:0]        r2_d;
    logic               active_d;
    logic               unused_bits;

    logic [19:0]        s1_r2;
    logic signed [10:0] s1_dot;
    logic               s1_active;
    logic               s1_frame;

    logic               vis_d;
    logic [19:0]        ring_diff;
    logic [11:0]        t;
    logic signed [13:0] base_full;
    logic [6:0]         base7;
    logic [7:0]         luma_sum;
    logic [6:0]         luma_half;
    logic [5:0]         luma_d;

    // Angle only moves at vblank start so shading is constant across a frame.
`ifdef DONUT_SPIN_EN
    always_ff @(posedge clk50 or negedge rst_n) begin
        if (!rst_n) begin
            angle <= '0;
        end else if (h_count == 11'd0 && v_count == 10'd480) begin
            angle <= angle + 8'd1;
        end
    end
`else
    always_ff @(posedge clk50 or negedge rst_n) begin
        if (!rst_n) begin
            angle <= '0;
        end else begin
            angle <= '0;
        end
    end
`endif

    assign rom_idx     = angle[7:2];
    assign sin_val     = sine_rom(rom_idx);
    assign cos_val     = sine_rom(rom_idx + 6'd16);
    assign unused_bits = ^{h_count[0], angle[1:0]};

    // Stage 0: centre-relative coordinates, squared radius and light dot product.
    always_comb begin
        dx        = $signed({1'b0, h_count[10:1]}) - 11'sd320;
        dy        = $signed({1'b0, v_count}) - 11'sd240;
        dx_ext    = {{9{dx[10]}}, dx};
        dy_ext    = {{9{dy[10]}}, dy};
        dx_sq     = dx_ext * dx_ext;
        dy_sq     = dy_ext * dy_ext;
        r2_d      = dx_sq + dy_sq;
        dot_sum   = dx_ext * {{12{cos_val[7]}}, cos_val}
                  + dy_ext * {{12{sin_val[7]}}, sin_val};
        dot_shift = dot_sum >>> 9;
        active_d  = (h_count < 11'd1280) && (v_count < 10'd480);
    end

    always_ff @(posedge clk50 or negedge rst_n) begin
        if (!rst_n) begin
            s1_r2     <= '0;
            s1_dot    <= '0;
            s1_active <= 1'b0;
            s1_frame  <= 1'b0;
        end else begin
            s1_r2     <= r2_d;
            s1_dot    <= 11'(dot_shift);
            s1_active <= active_d;
            s1_frame  <= frame;
        end
    end

    // Stage 1: ring membership, distance-from-tube-centre falloff, clamp and dither.
    always_comb begin
        vis_d     = s1_active && (s1_r2 >= 20'd3600) && (s1_r2 <= 20'd32400);
        ring_diff = (s1_r2 >= 20'd14400) ? (s1_r2 - 20'd14400) : (20'd14400 - s1_r2);
        t         = 12'(ring_diff >> 8);
        base_full = 14'sd64 + 14'(s1_dot) - $signed({2'b00, t});
        if (base_full < 14'sd0) begin
            base7 = '0;
        end else if (base_full > 14'sd127) begin
            base7 = 7'd127;
        end else begin
            base7 = 7'(base_full);
        end
        luma_sum  = {1'b0, base7} + {7'b0, s1_frame};
        luma_half = 7'(luma_sum >> 1);
        luma_d    = '0;
        if (vis_d) begin
            luma_d = (luma_half > 7'd63) ? 6'd63 : 6'(luma_half);
        end
    end

    always_ff @(posedge clk50 or negedge rst_n) begin
        if (!rst_n) begin
            donut_luma    <= '0;
            donut_visible <= 1'b0;
        end else begin
            donut_luma    <= luma_d;
            donut_visible <= vis_d;
        end
    end

endmodule

// File: tb/tb_donut.sv
// Self-checking bench for donut: directed vector table, spin sequence and a
// randomized stream compared against a real-arithmetic reference model.
module tb_donut;

    logic        clk50 = 1'b0;
    logic        rst_n;
    logic [10:0] h_count;
    logic [9:0]  v_count;
    logic        frame;
    logic [5:0]  donut_luma;
    logic        donut_visible;

    donut dut (
        .clk50        (clk50),
        .rst_n        (rst_n),
        .h_count      (h_count),
        .v_count      (v_count),
        .frame        (frame),
        .donut_luma   (donut_luma),
        .donut_visible(donut_visible)
    );

    always #10 clk50 = ~clk50;

    typedef struct {
        int h;
        int v;
        int f;
        int exp_vis;
        int exp_luma;
    } vec_t;

    typedef struct {
        int vis;
        int luma;
    } exp_t;

    int   n_tests = 0;
    int   n_fail  = 0;
    int   sin_tab[64];
    int   model_angle = 0;
    exp_t pend[$];
    vec_t vecs[14];

    function automatic void ref_pix(input int h, input int v, input int f, input int a,
                                    output int vis, output int luma);
        int dx, dy, r2, idx, s, c, t, dot, base;
        dx   = h / 2 - 320;
        dy   = v - 240;
        r2   = dx * dx + dy * dy;
        vis  = (h < 1280 && v < 480 && r2 >= 3600 && r2 <= 32400) ? 1 : 0;
        idx  = a / 4;
        s    = sin_tab[idx];
        c    = sin_tab[(idx + 16) % 64];
        t    = ((r2 >= 14400) ? (r2 - 14400) : (14400 - r2)) / 256;
        dot  = $rtoi($floor(real'(dx * c + dy * s) / 512.0));
        base = 64 + dot - t;
        if (base < 0) base = 0;
        if (base > 127) base = 127;
        luma = (base + f) / 2;
        if (luma > 63) luma = 63;
        if (vis == 0) luma = 0;
    endfunction

    task automatic check(input string name, input int exp_vis, input int exp_luma);
        n_tests++;
        if (int'(donut_visible) != exp_vis || int'(donut_luma) != exp_luma) begin
            n_fail++;
            $display("FAIL %s: got visible=%0d luma=%0d, expected visible=%0d luma=%0d",
                     name, donut_visible, donut_luma, exp_vis, exp_luma);
        end
    endtask

    task automatic step(input int h, input int v, input int f);
        h_count = 11'(h);
        v_count = 10'(v);
        frame   = f[0];
        @(posedge clk50);
        #1;
`ifdef DONUT_SPIN_EN
        if (h == 0 && v == 480) model_angle = (model_angle + 1) % 256;
`endif
    endtask

    task automatic stream(input int h, input int v, input int f);
        exp_t e;
        ref_pix(h, v, f, model_angle, e.vis, e.luma);
        pend.push_back(e);
        step(h, v, f);
        if (pend.size() == 2) begin
            e = pend.pop_front();
            check("stream", e.vis, e.luma);
        end
    endtask

    task automatic do_reset();
        exp_t z;
        #4;
        rst_n   = 1'b0;
        h_count = 11'($urandom_range(0, 1599));
        v_count = 10'($urandom_range(0, 524));
        frame   = 1'($urandom);
        #1;
        check("reset_async", 0, 0);
        @(posedge clk50);
        #1;
        check("reset_held", 0, 0);
        @(negedge clk50);
        rst_n       = 1'b1;
        model_angle = 0;
        pend.delete();
        z.vis  = 0;
        z.luma = 0;
        pend.push_back(z);
    endtask

    task automatic hold_check(input string name, input int h, input int v, input int f,
                              input int exp_vis, input int exp_luma);
        step(h, v, f);
        step(h, v, f);
        check(name, exp_vis, exp_luma);
    endtask

    initial begin
        real sv;
        int  h, v, f;
        for (int i = 0; i < 64; i++) begin
            sv = 127.0 * $sin(2.0 * 3.14159265358979 * i / 64.0);
            sin_tab[i] = (sv >= 0.0) ? $rtoi(sv + 0.5) : -$rtoi(-sv + 0.5);
        end

        vecs[0]  = '{640,  240, 0, 0, 0};
        vecs[1]  = '{1300, 240, 0, 0, 0};
        vecs[2]  = '{1300, 100, 1, 0, 0};
        vecs[3]  = '{700,  500, 0, 0, 0};
        vecs[4]  = '{880,  240, 0, 1, 46};
        vecs[5]  = '{880,  240, 1, 1, 47};
        vecs[6]  = '{400,  240, 0, 1, 17};
        vecs[7]  = '{1000, 240, 0, 1, 19};
        vecs[8]  = '{1001, 240, 0, 1, 19};
        vecs[9]  = '{1002, 240, 0, 0, 0};
        vecs[10] = '{760,  240, 0, 1, 18};
        vecs[11] = '{758,  240, 0, 0, 0};
        vecs[12] = '{1280, 240, 0, 0, 0};
        vecs[13] = '{880,  480, 0, 0, 0};

        rst_n   = 1'b1;
        h_count = '0;
        v_count = '0;
        frame   = 1'b0;
        @(posedge clk50);
        #1;
        do_reset();

        for (int i = 0; i < 14; i++) begin
            hold_check($sformatf("vec%0d_h%0d_v%0d_f%0d", i, vecs[i].h, vecs[i].v, vecs[i].f),
                       vecs[i].h, vecs[i].v, vecs[i].f, vecs[i].exp_vis, vecs[i].exp_luma);
        end

        // Two-clock latency: the lit pixel must not appear after only one edge.
        step(640, 240, 0);
        step(640, 240, 0);
        step(880, 240, 0);
        check("latency_one_edge", 0, 0);
        step(880, 240, 0);
        check("latency_two_edges", 1, 46);

        for (int i = 0; i < 64; i++) step(0, 480, 0);
`ifdef DONUT_SPIN_EN
        hold_check("spin_64_vblanks", 640, 360, 0, 1, 46);
`else
        hold_check("spin_64_vblanks", 640, 360, 0, 1, 32);
`endif

        do_reset();
        hold_check("angle_after_reset", 880, 240, 0, 1, 46);

        do_reset();
        for (int i = 0; i < 4000; i++) begin
            if (i == 2000) do_reset();
            if ($urandom_range(0, 39) == 0) begin
                h = 0;
                v = 480;
            end else if ($urandom_range(0, 1) == 0) begin
                h = $urandom_range(0, 1599);
                v = $urandom_range(0, 524);
            end else begin
                h = 270 + $urandom_range(0, 740);
                v = 50 + $urandom_range(0, 380);
            end
            f = $urandom_range(0, 1);
            stream(h, v, f);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
